// File: rtl/sysarray_counter_bank.sv
// Bank of independent up/down counters with per-channel step, wrap or saturate arithmetic and registered flags.
// All outputs are registered and update one cycle after the strobes; clken_i stalls the bank with no backpressure.
module sysarray_counter_bank #(
    parameter int                 C_WIDTH      = 8,
    parameter int                 C_NUM_CH     = 4,
    parameter int                 C_STEP_WIDTH = 4,
    parameter bit                 C_SATURATE   = 1'b0,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clken_i,
    input  logic [C_NUM_CH-1:0]            load_i,
    input  logic [C_NUM_CH-1:0]            incr_i,
    input  logic [C_NUM_CH-1:0]            decr_i,
    input  logic [C_NUM_CH*C_WIDTH-1:0]    load_value_i,
    input  logic [C_NUM_CH*C_STEP_WIDTH-1:0] step_i,
    output logic [C_NUM_CH*C_WIDTH-1:0]    count_o,
    output logic [C_NUM_CH-1:0]            is_zero_o,
    output logic [C_NUM_CH-1:0]            is_max_o,
    output logic [C_NUM_CH-1:0]            ovf_o,
    output logic                           all_zero_o
);

    localparam logic [C_WIDTH-1:0] C_MAX = '1;

    logic [C_NUM_CH*C_WIDTH-1:0] count_q, count_d;
    logic [C_NUM_CH-1:0]         is_zero_q, is_zero_d;
    logic [C_NUM_CH-1:0]         is_max_q, is_max_d;
    logic [C_NUM_CH-1:0]         ovf_q, ovf_d;

    for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
        logic [C_WIDTH:0]   step_ext;
        logic [C_WIDTH:0]   sum;
        logic [C_WIDTH:0]   diff;
        logic [C_WIDTH-1:0] cur;
        logic [C_WIDTH-1:0] nxt;
        logic               ovf_n;

        assign cur      = count_q[g*C_WIDTH +: C_WIDTH];
        assign step_ext = (C_WIDTH+1)'(step_i[g*C_STEP_WIDTH +: C_STEP_WIDTH]);
        // MSB of the extended result is the carry-out (incr) or borrow (decr).
        assign sum      = {1'b0, cur} + step_ext;
        assign diff     = {1'b0, cur} - step_ext;

        always_comb begin
            nxt   = cur;
            ovf_n = 1'b0;
            if (load_i[g]) begin
                nxt = load_value_i[g*C_WIDTH +: C_WIDTH];
            end else if (incr_i[g] && !decr_i[g]) begin
                nxt   = (C_SATURATE && sum[C_WIDTH]) ? C_MAX : sum[C_WIDTH-1:0];
                ovf_n = sum[C_WIDTH];
            end else if (decr_i[g] && !incr_i[g]) begin
                nxt   = (C_SATURATE && diff[C_WIDTH]) ? '0 : diff[C_WIDTH-1:0];
                ovf_n = diff[C_WIDTH];
            end
        end

        assign count_d[g*C_WIDTH +: C_WIDTH] = nxt;
        assign is_zero_d[g] = (nxt == '0);
        assign is_max_d[g]  = (nxt == C_MAX);
        assign ovf_d[g]     = ovf_n;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= {C_NUM_CH{C_INIT}};
            is_zero_q <= {C_NUM_CH{(C_INIT == '0)}};
            is_max_q  <= {C_NUM_CH{(C_INIT == C_MAX)}};
            ovf_q     <= '0;
        end else if (clken_i) begin
            count_q   <= count_d;
            is_zero_q <= is_zero_d;
            is_max_q  <= is_max_d;
            ovf_q     <= ovf_d;
        end else begin
            ovf_q     <= '0;
        end
    end

    assign count_o    = count_q;
    assign is_zero_o  = is_zero_q;
    assign is_max_o   = is_max_q;
    assign ovf_o      = ovf_q;
    assign all_zero_o = &is_zero_q;

endmodule

// File: tb/tb_sysarray_counter_bank.sv
// Directed bench: one wrap-mode and one saturate-mode bank driven by the same strobes.
module tb_sysarray_counter_bank;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clken;
    logic [N-1:0]  load, incr, decr;
    logic [W-1:0]  lv [N];
    logic [SW-1:0] st [N];
    logic [N*W-1:0]  load_value;
    logic [N*SW-1:0] step;

    assign load_value = {lv[3], lv[2], lv[1], lv[0]};
    assign step       = {st[3], st[2], st[1], st[0]};

    logic [N*W-1:0] w_count, s_count;
    logic [N-1:0]   w_zero, w_max, w_ovf, s_zero, s_max, s_ovf;
    logic           w_allz, s_allz;

    sysarray_counter_bank #(
        .C_WIDTH(W), .C_NUM_CH(N), .C_STEP_WIDTH(SW), .C_SATURATE(1'b0), .C_INIT(8'd0)
    ) u_wrap (
        .clk_i(clk), .rst_i(rst), .clken_i(clken),
        .load_i(load), .incr_i(incr), .decr_i(decr),
        .load_value_i(load_value), .step_i(step),
        .count_o(w_count), .is_zero_o(w_zero), .is_max_o(w_max),
        .ovf_o(w_ovf), .all_zero_o(w_allz)
    );

    sysarray_counter_bank #(
        .C_WIDTH(W), .C_NUM_CH(N), .C_STEP_WIDTH(SW), .C_SATURATE(1'b1), .C_INIT(8'd0)
    ) u_sat (
        .clk_i(clk), .rst_i(rst), .clken_i(clken),
        .load_i(load), .incr_i(incr), .decr_i(decr),
        .load_value_i(load_value), .step_i(step),
        .count_o(s_count), .is_zero_o(s_zero), .is_max_o(s_max),
        .ovf_o(s_ovf), .all_zero_o(s_allz)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] wc(input int i);
        return w_count[i*W +: W];
    endfunction

    function automatic logic [W-1:0] sc(input int i);
        return s_count[i*W +: W];
    endfunction

    initial begin
        rst = 1'b1; clken = 1'b1;
        load = '0; incr = '0; decr = '0;
        for (int i = 0; i < N; i++) begin
            lv[i] = '0;
            st[i] = '0;
        end
        tick(); tick();
        rst = 1'b0;

        // reset state
        check("rst_count_w", w_count, 0);
        check("rst_zero_w", w_zero, 4'hF);
        check("rst_max_w", w_max, 0);
        check("rst_ovf_w", w_ovf, 0);
        check("rst_allz_w", w_allz, 1);
        check("rst_count_s", s_count, 0);
        check("rst_allz_s", s_allz, 1);

        // wrap sequence on ch0
        lv[0] = 8'd250; load = 4'b0001;
        tick();
        check("wrap_load", wc(0), 250);
        load = '0; incr = 4'b0001; st[0] = 4'd4;
        tick();
        check("wrap_inc1", wc(0), 254);
        check("wrap_inc1_ovf", w_ovf, 0);
        tick();
        check("wrap_inc2", wc(0), 2);
        check("wrap_inc2_ovf", w_ovf, 4'b0001);
        check("sat_inc2", sc(0), 255);
        check("sat_inc2_ovf", s_ovf, 4'b0001);
        incr = '0; decr = 4'b0001; st[0] = 4'd3;
        tick();
        check("wrap_dec", wc(0), 255);
        check("wrap_dec_ovf", w_ovf, 4'b0001);
        check("wrap_dec_max", w_max, 4'b0001);
        check("sat_dec", sc(0), 252);
        check("sat_dec_ovf", s_ovf, 0);
        decr = '0;
        tick();
        check("wrap_idle_ovf", w_ovf, 0);
        check("wrap_idle_hold", wc(0), 255);

        // saturate sequence on ch1
        lv[1] = 8'd253; load = 4'b0010;
        tick();
        load = '0; incr = 4'b0010; st[1] = 4'd5;
        tick();
        check("sat_clamp", sc(1), 255);
        check("sat_clamp_ovf", s_ovf, 4'b0010);
        check("sat_clamp_max", s_max, 4'b0010);
        check("wrap_ch1", wc(1), 2);
        tick();
        check("sat_clamp2", sc(1), 255);
        check("sat_clamp2_ovf", s_ovf, 4'b0010);
        check("wrap_ch1_b", wc(1), 7);
        incr = '0; lv[1] = 8'd3; load = 4'b0010;
        tick();
        load = '0; decr = 4'b0010; st[1] = 4'd3;
        tick();
        check("sat_exact0", sc(1), 0);
        check("sat_exact0_ovf", s_ovf, 0);
        check("sat_exact0_zero", s_zero[1], 1);
        check("wrap_exact0", wc(1), 0);

        // priority and simultaneity
        lv[2] = 8'd7; load = 4'b0100; incr = 4'b1100; decr = 4'b0110;
        st[1] = 4'd0; st[2] = 4'd2; st[3] = 4'd1;
        tick();
        check("prio_load", wc(2), 7);
        check("prio_ch3", wc(3), 1);
        check("prio_step0", wc(1), 0);
        load = '0; decr = 4'b0100;
        tick();
        check("both_hold", wc(2), 7);
        check("both_ovf", w_ovf, 0);
        check("ind_ch3", wc(3), 2);

        // clken low holds state and masks ovf
        clken = 1'b0; incr = 4'hF; decr = '0;
        for (int i = 0; i < N; i++) st[i] = 4'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ce_ch0", wc(0), 255);
            check("ce_ch3", wc(3), 2);
            check("ce_ovf", w_ovf, 0);
        end

        // reset beats a simultaneous load
        clken = 1'b1; incr = '0; rst = 1'b1; load = 4'b0001; lv[0] = 8'd9;
        tick();
        rst = 1'b0; load = '0;
        check("rstld_count", w_count, 0);
        check("rstld_zero", w_zero, 4'hF);
        check("rstld_max", w_max, 0);

        // all_zero after the last channel drains
        for (int i = 0; i < N; i++) lv[i] = 8'd1;
        load = 4'hF;
        tick();
        load = '0;
        check("az_loaded", w_allz, 0);
        check("az_zero", w_zero, 0);
        for (int i = 0; i < N; i++) begin
            decr = 4'(1 << i);
            tick();
            check("az_ch", wc(i), 0);
            check("az_flag", w_allz, (i == N-1) ? 1 : 0);
        end
        decr = '0;
        tick();
        check("az_final", s_allz, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=0 expected=1");
        $fatal(1, "timeout");
    end

endmodule
